// File: rtl/uart_tx_frame_sequencer_pkg.sv
// Shared definitions for the UART transmit frame sequencer.
// Holds the FSM state encoding and the widths of the per-frame counters.
// The counter widths are sized for the widest legal frame (9 data bits,
// 2 stop bits), so every legal DATA_WIDTH fits.
package uart_tx_frame_sequencer_pkg;

   localparam int MAX_DATA_WIDTH = 9;
   localparam int BIT_CNT_W      = 4;   // indexes data bits 0..MAX_DATA_WIDTH-1
   localparam int STOP_CNT_W     = 1;   // counts stop ticks 0..1

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

endpackage

// File: rtl/uart_tx_frame_sequencer_parity_calc.sv
// parity_calc: parity bit for one UART frame.
// Ports:
//   data_i    [DATA_WIDTH-1:0]  data bits of the frame
//   par_typ_i                   0 = even, 1 = odd
//   par_o                       parity bit to place on the line
module parity_calc #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  par_typ_i,
   output logic                  par_o
);

   // Even parity is the XOR of the data bits; odd parity is its inverse.
   assign par_o = (^data_i) ^ par_typ_i;

endmodule

// File: rtl/uart_tx_frame_sequencer.sv
// uart_tx_frame_sequencer: serialises parallel words into UART frames
// (start, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stops).
// Ports:
//   CLK         system clock, rising edge
//   RST         synchronous active-low reset
//   Baud_Tick   one-cycle strobe; the line advances only on these cycles
//   P_DATA      word to send, qualified by Data_Valid
//   Data_Valid  P_DATA valid this cycle
//   Ready       holding buffer empty; a valid word is taken this cycle
//   PAR_EN      append parity bit
//   PAR_TYP     0 = even, 1 = odd parity
//   STOP2       two stop bits (forced off when STOP_MAX = 1)
//   TX_OUT      registered serial line, idles high
//   Busy        FSM not idle
module uart_tx_frame_sequencer
   import uart_tx_frame_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_MAX   = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  Baud_Tick,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   output logic                  Ready,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_WIDTH - 1);
   localparam logic                 HAS_STOP2 = (STOP_MAX >= 2);

   // One-entry holding buffer
   logic                  buf_full_q;
   logic [DATA_WIDTH-1:0] buf_data_q;
   logic                  buf_par_en_q;
   logic                  buf_par_typ_q;
   logic                  buf_stop2_q;

   // Frame being transmitted; parity is computed once at load time so the
   // frame never depends on live inputs.
   tx_state_e             state_q;
   logic [DATA_WIDTH-1:0] sh_q;
   logic                  par_en_q;
   logic                  par_bit_q;
   logic                  stop2_q;
   logic [BIT_CNT_W-1:0]  bit_cnt_q;
   logic [STOP_CNT_W-1:0] stop_cnt_q;
   logic                  tx_q;

   logic                  buf_par_bit;
   logic                  stop_done;
   logic                  frame_load;

   parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
      .data_i    (buf_data_q),
      .par_typ_i (buf_par_typ_q),
      .par_o     (buf_par_bit)
   );

   // Last stop tick: first tick unless two stops were latched.
   assign stop_done  = !(stop2_q && (stop_cnt_q == '0));
   // Buffer moves into the shifter either from IDLE or straight out of the
   // final stop tick (back-to-back frames, no idle bit in between).
   assign frame_load = Baud_Tick && buf_full_q &&
                       ((state_q == IDLE) || ((state_q == STOP) && stop_done));

   assign Ready  = !buf_full_q;
   assign Busy   = (state_q != IDLE);
   assign TX_OUT = tx_q;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         buf_full_q    <= 1'b0;
         buf_data_q    <= '0;
         buf_par_en_q  <= 1'b0;
         buf_par_typ_q <= 1'b0;
         buf_stop2_q   <= 1'b0;
         state_q       <= IDLE;
         sh_q          <= '0;
         par_en_q      <= 1'b0;
         par_bit_q     <= 1'b0;
         stop2_q       <= 1'b0;
         bit_cnt_q     <= '0;
         stop_cnt_q    <= '0;
         tx_q          <= 1'b1;
      end else begin
         // Capture and load are exclusive: capture needs an empty buffer,
         // load needs a full one.
         if (frame_load) begin
            buf_full_q <= 1'b0;
            sh_q       <= buf_data_q;
            par_en_q   <= buf_par_en_q;
            par_bit_q  <= buf_par_bit;
            stop2_q    <= buf_stop2_q;
         end else if (Data_Valid && !buf_full_q) begin
            buf_full_q    <= 1'b1;
            buf_data_q    <= P_DATA;
            buf_par_en_q  <= PAR_EN;
            buf_par_typ_q <= PAR_TYP;
            buf_stop2_q   <= STOP2 & HAS_STOP2;
         end

         if (Baud_Tick) begin
            case (state_q)
               IDLE: begin
                  if (buf_full_q) begin
                     state_q <= START;
                     tx_q    <= 1'b0;
                  end
               end
               START: begin
                  state_q   <= DATA;
                  tx_q      <= sh_q[0];
                  sh_q      <= sh_q >> 1;
                  bit_cnt_q <= '0;
               end
               DATA: begin
                  // bit_cnt_q is the index of the bit currently on the line
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_q <= '0;
                     if (par_en_q) begin
                        state_q <= PARITY;
                        tx_q    <= par_bit_q;
                     end else begin
                        state_q    <= STOP;
                        tx_q       <= 1'b1;
                        stop_cnt_q <= '0;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     tx_q      <= sh_q[0];
                     sh_q      <= sh_q >> 1;
                  end
               end
               PARITY: begin
                  state_q    <= STOP;
                  tx_q       <= 1'b1;
                  stop_cnt_q <= '0;
               end
               STOP: begin
                  if (!stop_done) begin
                     stop_cnt_q <= stop_cnt_q + 1'b1;
                  end else begin
                     stop_cnt_q <= '0;
                     if (buf_full_q) begin
                        state_q <= START;
                        tx_q    <= 1'b0;
                     end else begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                     end
                  end
               end
               default: begin
                  state_q <= IDLE;
                  tx_q    <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/uart_tx_frame_sequencer.md
UART_TX_FRAME_SEQUENCER -- requirements
Module: uart_tx_frame_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame (legal range 5..9).
REQ-002 SHALL have parameter STOP_MAX, default 2, meaning maximum stop bits supported (1 or 2).
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port Baud_Tick  input  1  one-cycle strobe; frame state advances only on cycles where it is high.
REQ-006 SHALL have port P_DATA  input  DATA_WIDTH  parallel word to transmit.
REQ-007 SHALL have port Data_Valid  input  1  P_DATA is valid this cycle.
REQ-008 SHALL have port Ready  output  1  holding buffer is empty and a word is accepted this cycle.
REQ-009 SHALL have port PAR_EN  input  1  parity bit appended when 1.
REQ-010 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-011 SHALL have port STOP2  input  1  two stop bits when 1 (ignored when STOP_MAX=1).
REQ-012 SHALL have port TX_OUT  output  1  registered serial line, idle high.
REQ-013 SHALL have port Busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-014 SHALL capture P_DATA, PAR_EN, PAR_TYP and STOP2 into a one-entry holding buffer on any cycle where Data_Valid and Ready are both high.
REQ-015 SHALL ignore Data_Valid while Ready is low; no word is dropped or overwritten.
REQ-016 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 SHALL, in IDLE with buffer full on a Baud_Tick, move the buffer into the shift register, go to START, drive TX_OUT=0 from the next edge, and free the buffer (Ready high next cycle).
REQ-018 SHALL, on each Baud_Tick: START->DATA, emitting bit 0; DATA emits DATA_WIDTH bits LSB first using a bit counter; after the last bit go to PARITY if latched PAR_EN, else STOP.
REQ-019 SHALL drive the parity bit as XOR of the frame's data bits (even) or its inverse (odd), computed from the latched frame, not live inputs.
REQ-020 SHALL hold TX_OUT=1 for 1 or 2 ticks in STOP per the latched STOP2.
REQ-021 SHALL, at the end of STOP, go directly to START (no idle tick) if the buffer is full, otherwise go to IDLE.
REQ-022 SHALL not advance state, counters or TX_OUT on cycles without Baud_Tick.
REQ-023 SHALL, if Data_Valid arrives in IDLE on the same cycle as Baud_Tick with the buffer empty, only capture; the frame starts on the next Baud_Tick.
REQ-024 SHALL ignore PAR_EN/PAR_TYP/STOP2 changes during a frame; they apply only to subsequently captured words.

Reset
REQ-025 SHALL, on RST low at a rising CLK edge, including mid-frame, force IDLE, TX_OUT=1, Busy=0, Ready=1, empty buffer, and zeroed counters; any partial frame is abandoned.

Structure
REQ-026 SHALL place state encodings and the frame-field widths in the shared UART package/include file.
REQ-027 SHALL instantiate one sub-module, parity_calc (DATA_WIDTH data, PAR_TYP in, one parity bit out).

Verification
REQ-028 SHALL test 0xA5, PAR_EN=1, PAR_TYP=0, STOP2=0 -> TX_OUT per tick: 0,1,0,1,0,0,1,0,1,0,1; Busy high for 11 ticks.
REQ-029 SHALL test 0xA5 with PAR_TYP=1, STOP2=1 -> parity bit 1, two stop ticks, 12-tick frame.
REQ-030 SHALL test back-to-back: 0x00 then 0xFF presented while the first frame is in DATA -> second START on the tick immediately after the first STOP, with no idle high tick; Ready low until that START.
REQ-031 SHALL test Data_Valid with Ready low -> word not captured; the held word is transmitted once the sender retries.
REQ-032 SHALL test RST low during the DATA bit 4 -> next edge TX_OUT=1, Busy=0, Ready=1; a new word then sends a full clean frame.
REQ-033 SHALL test DATA_WIDTH=7, PAR_EN=0 with Baud_Tick every 16 clocks -> 9-tick frame; TX_OUT changes only on tick cycles.
